// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of the HyperBus leader controller.
// Drives the hold-high wrq/rrq handshake for exactly len words, then enforces an idle gap.
`timescale 1ns/1ps
module hyperbus_arbiter #(
  parameter int DW          = 16,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_W       = 8,
  parameter int GAP_COUNT   = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic                   p0_reg,
  input  logic [ADDR_LENGTH-1:0] p0_adr,
  input  logic [LEN_W-1:0]       p0_len,
  output logic                   p0_ack,
  input  logic [DW-1:0]          p0_wdat,
  input  logic [DW/8-1:0]        p0_wmask,
  output logic                   p0_wready,
  output logic [DW-1:0]          p0_rdat,
  output logic                   p0_rvalid,
  output logic                   p0_done,
  output logic                   p0_err,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic                   p1_reg,
  input  logic [ADDR_LENGTH-1:0] p1_adr,
  input  logic [LEN_W-1:0]       p1_len,
  output logic                   p1_ack,
  input  logic [DW-1:0]          p1_wdat,
  input  logic [DW/8-1:0]        p1_wmask,
  output logic                   p1_wready,
  output logic [DW-1:0]          p1_rdat,
  output logic                   p1_rvalid,
  output logic                   p1_done,
  output logic                   p1_err,
  output logic [ADDR_LENGTH-1:0] ctl_adr,
  output logic                   ctl_reg,
  output logic [DW-1:0]          ctl_dat,
  output logic [DW/8-1:0]        ctl_mask,
  output logic                   ctl_wrq,
  output logic                   ctl_rrq,
  input  logic                   ctl_ready,
  input  logic                   ctl_valid,
  input  logic [DW-1:0]          ctl_rdat
);
  localparam int MW = DW / 8;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_COUNT > 1) ? $clog2(GAP_COUNT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_WRITE, S_READ, S_GAP} state_t;
  state_t state_reg, state_next;

  logic [1:0]                  req, we, rg;
  logic [1:0][ADDR_LENGTH-1:0] adr;
  logic [1:0][LEN_W-1:0]       len;
  logic [1:0][DW-1:0]          wdat, rdat;
  logic [1:0][MW-1:0]          wmask;
  logic [1:0]                  ack, wready, rvalid, done, err;

  logic                   rr_reg, gnt_reg, sel, any_req;
  logic [ADDR_LENGTH-1:0] adr_reg;
  logic                   reg_reg;
  logic [LEN_W-1:0]       len_reg, beat_reg;
  logic [SW-1:0]          stall_reg;
  logic [GW-1:0]          gap_reg;
  logic                   wrq_reg, rrq_reg;
  logic                   last_beat, timed_out, wr_take, rd_take;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign rg    = {p1_reg, p0_reg};
  assign adr   = {p1_adr, p0_adr};
  assign len   = {p1_len, p0_len};
  assign wdat  = {p1_wdat, p0_wdat};
  assign wmask = {p1_wmask, p0_wmask};

  assign {p1_ack, p0_ack}       = ack;
  assign {p1_wready, p0_wready} = wready;
  assign {p1_rvalid, p0_rvalid} = rvalid;
  assign {p1_done, p0_done}     = done;
  assign {p1_err, p0_err}       = err;
  assign p0_rdat                = rdat[0];
  assign p1_rdat                = rdat[1];

  assign ctl_adr = adr_reg;
  assign ctl_reg = reg_reg;
  assign ctl_wrq = wrq_reg;
  assign ctl_rrq = rrq_reg;

  always_comb begin
    any_req   = |req;
    sel       = (&req) ? rr_reg : req[1];
    last_beat = (beat_reg == len_reg);
    timed_out = (stall_reg == SW'(TIMEOUT));
    wr_take   = (state_reg == S_WRITE) && ctl_ready && !last_beat;
    rd_take   = (state_reg == S_READ) && ctl_valid && !last_beat && !timed_out;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req) state_next = S_ARB;
      // A request withdrawn before the grant cycle simply returns to IDLE.
      S_ARB:   state_next = !any_req ? S_IDLE : (we[sel] ? S_WRITE : S_READ);
      S_WRITE: if (last_beat) state_next = S_GAP;
      S_READ:  if (last_beat || timed_out) state_next = S_GAP;
      S_GAP:   if (gap_reg == GW'(GAP_COUNT - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack      = '0;
    wready   = '0;
    rvalid   = '0;
    done     = '0;
    err      = '0;
    ctl_dat  = '0;
    ctl_mask = '1;
    ack[sel]        = (state_reg == S_ARB) && any_req;
    wready[gnt_reg] = wr_take;
    rvalid[gnt_reg] = rd_take;
    done[gnt_reg]   = ((state_reg == S_WRITE) && last_beat) ||
                      ((state_reg == S_READ) && (last_beat || timed_out));
    err[gnt_reg]    = (state_reg == S_READ) && timed_out && !last_beat;
    // Overrun slots past the last word are fully masked so the controller writes nothing.
    if ((state_reg == S_WRITE) && !last_beat) begin
      ctl_dat  = wdat[gnt_reg];
      ctl_mask = wmask[gnt_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdat
      assign rdat[gi] = ((state_reg == S_READ) && (gnt_reg == 1'(gi))) ? ctl_rdat : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_reg    <= 1'b0;
      gnt_reg   <= 1'b0;
      adr_reg   <= '0;
      reg_reg   <= 1'b0;
      len_reg   <= '0;
      beat_reg  <= '0;
      stall_reg <= '0;
      gap_reg   <= '0;
      wrq_reg   <= 1'b0;
      rrq_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_ARB: if (any_req) begin
          gnt_reg   <= sel;
          rr_reg    <= ~sel;
          adr_reg   <= adr[sel];
          reg_reg   <= rg[sel];
          len_reg   <= (len[sel] == '0) ? LEN_W'(1) : len[sel];
          beat_reg  <= '0;
          stall_reg <= '0;
          gap_reg   <= '0;
          wrq_reg   <= we[sel];
          rrq_reg   <= ~we[sel];
        end
        S_WRITE: if (wr_take) begin
          beat_reg <= beat_reg + LEN_W'(1);
          if (beat_reg + LEN_W'(1) == len_reg) wrq_reg <= 1'b0;
        end
        S_READ: begin
          if (rd_take) begin
            beat_reg  <= beat_reg + LEN_W'(1);
            stall_reg <= '0;
            if (beat_reg + LEN_W'(1) == len_reg) rrq_reg <= 1'b0;
          end else if (!last_beat && !timed_out) begin
            stall_reg <= stall_reg + SW'(1);
            if (stall_reg + SW'(1) == SW'(TIMEOUT)) rrq_reg <= 1'b0;
          end
        end
        S_GAP: gap_reg <= gap_reg + GW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Bench for hyperbus_arbiter: emulates the controller side cycle by cycle and checks each
// burst against the port-level rules (word counts, grant order, gaps, timeout latency).
`timescale 1ns/1ps
module tb_hyperbus_arbiter;
  localparam int DW = 16, AW = 32, LW = 8, GAPC = 4, TIMEOUT = 64;

  logic clk = 1'b0, rstn = 1'b0;
  logic p0_req = 0, p0_we = 0, p0_reg = 0, p1_req = 0, p1_we = 0, p1_reg = 0;
  logic [AW-1:0] p0_adr = '0, p1_adr = '0;
  logic [LW-1:0] p0_len = '0, p1_len = '0;
  logic [DW-1:0] p0_wdat = '0, p1_wdat = '0, ctl_rdat = '0;
  logic [1:0]    p0_wmask = '0, p1_wmask = '0;
  logic          ctl_ready = 0, ctl_valid = 0;
  logic p0_ack, p0_wready, p0_rvalid, p0_done, p0_err;
  logic p1_ack, p1_wready, p1_rvalid, p1_done, p1_err;
  logic [DW-1:0] p0_rdat, p1_rdat, ctl_dat;
  logic [1:0]    ctl_mask;
  logic [AW-1:0] ctl_adr;
  logic          ctl_reg, ctl_wrq, ctl_rrq;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hyperbus_arbiter dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_reg(p0_reg), .p0_adr(p0_adr), .p0_len(p0_len),
    .p0_ack(p0_ack), .p0_wdat(p0_wdat), .p0_wmask(p0_wmask), .p0_wready(p0_wready),
    .p0_rdat(p0_rdat), .p0_rvalid(p0_rvalid), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_reg(p1_reg), .p1_adr(p1_adr), .p1_len(p1_len),
    .p1_ack(p1_ack), .p1_wdat(p1_wdat), .p1_wmask(p1_wmask), .p1_wready(p1_wready),
    .p1_rdat(p1_rdat), .p1_rvalid(p1_rvalid), .p1_done(p1_done), .p1_err(p1_err),
    .ctl_adr(ctl_adr), .ctl_reg(ctl_reg), .ctl_dat(ctl_dat), .ctl_mask(ctl_mask),
    .ctl_wrq(ctl_wrq), .ctl_rrq(ctl_rrq), .ctl_ready(ctl_ready), .ctl_valid(ctl_valid),
    .ctl_rdat(ctl_rdat)
  );

  wire [1:0] acks   = {p1_ack, p0_ack};
  wire [1:0] wrdy_v = {p1_wready, p0_wready};
  wire [1:0] rval_v = {p1_rvalid, p0_rvalid};
  wire [1:0] done_v = {p1_done, p0_done};
  wire [1:0] err_v  = {p1_err, p0_err};

  // supply: read words the emulated controller delivers before going silent
  typedef struct {
    int        port;
    bit        we;
    bit        rg;
    logic [31:0] adr;
    logic [7:0]  len;
    int        supply;
    int        prob;
    int        exp_words;
    bit        exp_err;
  } vec_t;

  int n_vec = 0, n_mis = 0;
  int model_rr = 0;
  int ack_cyc = 0, last_done_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rdat_of(input int p);
    return (p != 0) ? p1_rdat : p0_rdat;
  endfunction

  task automatic set_req(input int p, input bit r, input vec_t v);
    if (p == 0) begin
      p0_req = r; p0_we = v.we; p0_reg = v.rg; p0_adr = v.adr; p0_len = v.len;
    end else begin
      p1_req = r; p1_we = v.we; p1_reg = v.rg; p1_adr = v.adr; p1_len = v.len;
    end
  endtask

  task automatic set_wdat(input int p, input logic [DW-1:0] wd, input logic [1:0] wm);
    if (p == 0) begin p0_wdat = wd; p0_wmask = wm; end
    else        begin p1_wdat = wd; p1_wmask = wm; end
  endtask

  // Runs one burst for v.port; optionally holds the other port requesting with ov.
  // Entered and left at posedge+1.
  task automatic run_burst(input vec_t v, input bit hold_other, input vec_t ov);
    int p, o, eff, wcount, rcount, supplied, last_evt;
    bit got, done_seen, exp_wr, exp_rv;
    logic [DW-1:0] wd, rd;
    logic [1:0] wm;
    p = v.port; o = 1 - p;
    eff = (v.len == 0) ? 1 : int'(v.len);
    set_req(p, 1'b1, v);
    if (hold_other) set_req(o, 1'b1, ov);
    ctl_ready = 0; ctl_valid = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      chk("other_ack", 64'(acks[o]), 64'd0);
      if (acks[p]) begin got = 1; ack_cyc = cyc; end
      else begin @(posedge clk); #1; end
    end
    chk("ack_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    set_req(p, 1'b0, v);
    if (!got) return;
    model_rr = o;
    wcount = 0; rcount = 0; supplied = 0; last_evt = ack_cyc; done_seen = 0;
    for (int n = 0; n < 200 && !done_seen; n++) begin
      wd = DW'($urandom); wm = 2'($urandom); rd = DW'($urandom);
      set_wdat(p, wd, wm);
      ctl_rdat = rd; ctl_ready = 0; ctl_valid = 0;
      if (v.we) ctl_ready = ($urandom_range(99) < v.prob);
      else if ((supplied < v.supply || supplied >= eff) && $urandom_range(99) < v.prob) begin
        ctl_valid = 1; supplied++;
      end
      @(negedge clk);
      if (n == 0) begin
        chk("ctl_adr", 64'(ctl_adr), 64'(v.adr));
        chk("ctl_reg", 64'(ctl_reg), 64'(v.rg));
        chk("req_lines", 64'({ctl_wrq, ctl_rrq}), 64'({v.we, !v.we}));
      end
      chk("idle_port", 64'({acks[o], wrdy_v[o], rval_v[o], done_v[o], err_v[o]}), 64'd0);
      if (v.we) begin
        exp_wr = ctl_ready && (wcount < eff);
        chk("wready", 64'(wrdy_v[p]), 64'(exp_wr));
        if (exp_wr) begin
          chk("ctl_dat", 64'(ctl_dat), 64'(wd));
          chk("ctl_mask", 64'(ctl_mask), 64'(wm));
          wcount++; last_evt = cyc;
        end else if (ctl_ready) begin
          chk("ovr_slot", 64'({ctl_mask, ctl_dat}), 64'({2'b11, 16'h0}));
        end
      end else begin
        exp_rv = ctl_valid && (rcount < eff);
        chk("rvalid", 64'(rval_v[p]), 64'(exp_rv));
        if (exp_rv) begin
          chk("rdat", 64'(rdat_of(p)), 64'(rd));
          rcount++; last_evt = cyc;
        end
      end
      if (done_v[p]) begin
        done_seen = 1; last_done_cyc = cyc;
        chk("err", 64'(err_v[p]), 64'(v.exp_err));
        chk("words", 64'(v.we ? wcount : rcount), 64'(v.exp_words));
        chk("done_lines", 64'({ctl_wrq, ctl_rrq}), 64'd0);
        // a timeout fires after TIMEOUT silent cycles following the last word (or the grant)
        chk("done_lat", 64'(cyc - last_evt), 64'(v.exp_err ? TIMEOUT + 1 : 1));
        $display("burst p%0d %s adr=%h len=%0d words=%0d err=%0d @%0d", p,
                 v.we ? "WR" : "RD", v.adr, v.len, v.we ? wcount : rcount, err_v[p], cyc);
      end
      @(posedge clk); #1;
    end
    ctl_ready = 0; ctl_valid = 0;
    chk("done_seen", 64'(done_seen), 64'd1);
    for (int k = 0; k < GAPC; k++) begin
      @(negedge clk);
      chk("gap_idle", 64'({ctl_wrq, ctl_rrq, done_v[p]}), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t rand_vec(input int p);
    vec_t v; int eff;
    v.port = p;
    v.we   = 1'($urandom_range(1));
    v.rg   = 1'($urandom_range(1));
    v.adr  = $urandom;
    v.len  = ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
    v.prob = int'($urandom_range(30, 100));
    eff    = (v.len == 0) ? 1 : int'(v.len);
    v.supply = 99;
    if (!v.we && eff > 1 && $urandom_range(7) == 0) v.supply = int'($urandom_range(eff - 1));
    v.exp_words = (v.supply < eff) ? v.supply : eff;
    v.exp_err   = (v.supply < eff);
    return v;
  endfunction

  vec_t tbl[7];
  vec_t va, vb, vc;
  int prev, seen, w;
  bit got;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1, 0, 32'h0000_0100, 8'd4, 99, 100, 4, 0};  // back-to-back write slots
    tbl[1] = '{1, 0, 0, 32'h0000_0200, 8'd3, 99, 60, 3, 0};   // gappy read
    tbl[2] = '{0, 0, 1, 32'h0000_0300, 8'd2, 1, 100, 1, 1};   // stall after one word
    tbl[3] = '{0, 0, 0, 32'h0000_0310, 8'd5, 99, 100, 5, 0};  // normal read after a stall
    tbl[4] = '{1, 0, 0, 32'h0000_0400, 8'd1, 99, 100, 1, 0};  // extra valid after last word
    tbl[5] = '{1, 1, 1, 32'h0000_0500, 8'd0, 99, 100, 1, 0};  // len 0 behaves as 1
    tbl[6] = '{0, 1, 0, 32'hFFFF_FFFF, 8'd7, 99, 50, 7, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lines", 64'({ctl_wrq, ctl_rrq}), 64'd0);
    chk("rst_mask", 64'(ctl_mask), 64'h3);
    chk("rst_adr_dat", 64'({ctl_adr, ctl_dat}), 64'd0);
    chk("rst_ports", 64'({acks, wrdy_v, rval_v, done_v, err_v}), 64'd0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    // Simultaneous requests: p0 first, then p1 (rr), p0 re-requesting waits for p1.
    va = '{0, 1, 0, 32'h0000_1000, 8'd2, 99, 100, 2, 0};
    vb = '{1, 0, 0, 32'h0000_2000, 8'd3, 99, 100, 3, 0};
    vc = '{0, 0, 1, 32'h0000_3000, 8'd2, 99, 80, 2, 0};
    run_burst(va, 1, vb);
    prev = last_done_cyc;
    run_burst(vb, 1, vc);
    chk("rearb_gap_p1", 64'(ack_cyc - prev), 64'(GAPC + 2));
    prev = last_done_cyc;
    run_burst(vc, 0, vc);
    chk("rearb_gap_p0", 64'(ack_cyc - prev), 64'(GAPC + 2));

    // Request withdrawn before the grant cycle: no ack, no bus activity.
    set_req(1, 1'b1, vb);
    @(negedge clk); chk("drop_ack0", 64'(acks), 64'd0);
    @(posedge clk); #1; set_req(1, 1'b0, vb);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("drop_quiet", 64'({acks, ctl_wrq, ctl_rrq}), 64'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 7; i++) run_burst(tbl[i], 0, tbl[i]);

    // Reset in the middle of a write burst.
    va = '{0, 1, 0, 32'h0000_00AA, 8'd4, 99, 100, 4, 0};
    set_req(0, 1'b1, va); set_wdat(0, 16'h1234, 2'b00); ctl_ready = 1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (p0_ack) got = 1; else begin @(posedge clk); #1; end
    end
    chk("rstw_ack", 64'(got), 64'd1);
    @(posedge clk); #1; set_req(0, 1'b0, va);
    seen = 0;
    for (int k = 0; k < 10 && seen < 2; k++) begin
      @(negedge clk);
      if (p0_wready) seen++;
      if (seen < 2) begin @(posedge clk); #1; end
    end
    chk("rstw_beats", 64'(seen), 64'd2);
    chk("rstw_wrq_before", 64'(ctl_wrq), 64'd1);
    #1 rstn = 0;
    #1;
    chk("rstw_lines", 64'({ctl_wrq, ctl_rrq}), 64'd0);
    chk("rstw_ports", 64'({acks, wrdy_v, done_v, err_v}), 64'd0);
    chk("rstw_ctl", 64'({ctl_mask, ctl_dat}), 64'({2'b11, 16'h0}));
    chk("rstw_adr", 64'(ctl_adr), 64'd0);
    @(posedge clk); #1;
    ctl_ready = 0; rstn = 1; model_rr = 0;
    vb = '{1, 0, 0, 32'h0000_0BB0, 8'd2, 99, 100, 2, 0};
    run_burst(vb, 0, vb);

    // Randomised traffic; when both ports request, the model's rr pointer picks the winner.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(2) == 2) begin
        w  = model_rr;
        va = rand_vec(w);
        vb = rand_vec(1 - w);
        run_burst(va, 1, vb);
        run_burst(vb, 0, vb);
      end else begin
        va = rand_vec(int'($urandom_range(1)));
        run_burst(va, 0, va);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
